// File: rtl/pes_serial_pkg.sv
// Shared definitions for the 4-bit serial shift link.
// Used by the PISO transmitter and the matching SIPO receiver.
package pes_serial_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } pes_piso_state_e;

  localparam int PES_LINK_WIDTH = 4;

  // MSB_FIRST setting that selects LSB-first order on the link
  localparam bit PES_LSB_FIRST = 1'b0;

endpackage

// File: rtl/pes_bit_cnt.sv
// Modulo-WIDTH bit counter with sync clear, enable and terminal count.
// Ports: clk, rst (sync, active-high), clr, en -> cnt, tc (cnt==WIDTH-1).
module pes_bit_cnt #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     tc
);

  localparam int CW = $clog2(WIDTH);

  assign tc = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pes_piso.sv
// Parallel-in serial-out transmitter for the serial shift link.
// Ports: clk, rst, load_valid/load_data/load_ready, shift_en -> sout,
// sout_valid, frame_start, frame_last, busy.
module pes_piso
  import pes_serial_pkg::*;
#(
  parameter int WIDTH     = PES_LINK_WIDTH,
  parameter bit MSB_FIRST = PES_LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  pes_piso_state_e  state;
  pes_piso_state_e  state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             adv;
  logic             accept;

  assign adv = (state == SHIFT) && shift_en;

  // Ready on the last bit lets the next word follow with no gap
  assign load_ready = !rst &&
                      ((state == IDLE) || (last && adv));
  assign accept = load_valid && load_ready;

  pes_bit_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (adv),
    .cnt(cnt),
    .tc (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Zero fill keeps sout low once the block falls back to IDLE
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    if (accept) begin
      state_nxt = SHIFT;
      shreg_nxt = load_data;
    end else if (adv) begin
      if (last) begin
        state_nxt = IDLE;
        shreg_nxt = '0;
      end else if (MSB_FIRST) begin
        shreg_nxt = shreg << 1;
      end else begin
        shreg_nxt = shreg >> 1;
      end
    end
  end

  assign sout        = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign sout_valid  = (state == SHIFT);
  assign busy        = (state == SHIFT);
  assign frame_start = (state == SHIFT) && (cnt == '0);
  assign frame_last  = last;

endmodule

// File: tb/tb_pes_piso.sv
// Bench for pes_piso: LSB-first and MSB-first instances, word-queue model,
// behavioural SIPO loopback, directed steps then random words.
module tb_pes_piso;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic       shift_en = 1'b0;

  logic lr_l, sout_l, sv_l, fs_l, fl_l, busy_l;
  logic lr_m, sout_m, sv_m, fs_m, fl_m, busy_m;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pes_piso #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_l), .shift_en(shift_en),
    .sout(sout_l), .sout_valid(sv_l),
    .frame_start(fs_l), .frame_last(fl_l), .busy(busy_l)
  );

  pes_piso #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_m), .shift_en(shift_en),
    .sout(sout_m), .sout_valid(sv_m),
    .frame_start(fs_m), .frame_last(fl_m), .busy(busy_m)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream receivers: LSB-first shifts into the MSB, MSB-first into the LSB
  logic [3:0] sipo_l, sipo_m;
  always @(posedge clk) begin
    if (rst) begin
      sipo_l <= '0;
      sipo_m <= '0;
    end else if (shift_en) begin
      if (sv_l) sipo_l <= {sout_l, sipo_l[3:1]};
      if (sv_m) sipo_m <= {sipo_m[2:0], sout_m};
    end
  end

  // Model: queue of accepted words, index of the bit now on the wire
  logic [3:0] wq[$];
  int         idx = 0;
  logic       chk_pend = 1'b0;
  logic [3:0] chk_w;

  always @(negedge clk) begin : model
    logic [3:0] cur;
    logic       exp_ready;
    if (rst) begin
      check("rst_ready_l", lr_l, 0);
      check("rst_ready_m", lr_m, 0);
      wq.delete();
      idx = 0;
      chk_pend = 1'b0;
    end else begin
      if (chk_pend) begin
        check("loop_l", sipo_l, chk_w);
        check("loop_m", sipo_m, chk_w);
        chk_pend = 1'b0;
      end
      if (wq.size() > 0) begin
        cur = wq[0];
        check("m_valid_l", sv_l, 1);
        check("m_valid_m", sv_m, 1);
        check("m_busy", busy_l, 1);
        check("m_sout_l", sout_l, cur[idx]);
        check("m_sout_m", sout_m, cur[3-idx]);
        check("m_start", fs_l, idx == 0);
        check("m_last", fl_l, idx == 3);
        check("m_start_m", fs_m, idx == 0);
        check("m_last_m", fl_m, idx == 3);
        exp_ready = (idx == 3) && shift_en;
      end else begin
        check("m_idle_valid", {sv_l, sv_m}, 0);
        check("m_idle_sout", {sout_l, sout_m}, 0);
        check("m_idle_flags", {fs_l, fl_l, fs_m, fl_m}, 0);
        check("m_idle_busy", {busy_l, busy_m}, 0);
        exp_ready = 1'b1;
      end
      check("m_ready_l", lr_l, exp_ready);
      check("m_ready_m", lr_m, exp_ready);
      if (wq.size() > 0 && shift_en) begin
        if (idx == 3) begin
          chk_w = wq.pop_front();
          chk_pend = 1'b1;
          idx = 0;
        end else begin
          idx++;
        end
      end
      if (load_valid && exp_ready) wq.push_back(load_data);
    end
  end

  task automatic expect_bits(input string tag, input logic [3:0] sl,
                             input logic [3:0] sm);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_sout_l"}, sout_l, sl[i]);
      check({tag, "_sout_m"}, sout_m, sm[i]);
      check({tag, "_start"}, fs_l, i == 0);
      check({tag, "_last"}, fl_l, i == 3);
    end
  endtask

  task automatic load_word(input string tag, input logic [3:0] w,
                           input logic [3:0] sl, input logic [3:0] sm);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data = w;
    @(negedge clk);
    check({tag, "_acc"}, lr_l, 1);
    @(posedge clk); #1;
    load_valid = 1'b0;
    expect_bits(tag, sl, sm);
  endtask

  logic [7:0] seq;
  int         cyc;
  logic       acc;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", sv_l, 0);
    check("reset_busy", busy_l, 0);
    check("reset_sout", sout_l, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", lr_l, 1);
    check("post_rst_valid", sv_l, 0);

    shift_en = 1'b1;
    load_word("lsb1011", 4'b1011, 4'b1011, 4'b1101);
    @(negedge clk);
    check("t1_end_valid", sv_l, 0);

    seq = 8'b01011010;
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data = 4'hA;
    @(negedge clk);
    check("b2b_acc", lr_l, 1);
    @(posedge clk); #1;
    load_data = 4'h5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_sout", sout_l, seq[i]);
      check("b2b_valid", sv_l, 1);
      check("b2b_ready", lr_l, (i == 3) || (i == 7));
      check("b2b_start", fs_l, (i == 0) || (i == 4));
      if (i == 3) begin
        @(posedge clk); #1;
        load_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_end_valid", sv_l, 0);

    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data = 4'hC;
    @(negedge clk);
    check("stall_acc", lr_l, 1);
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(negedge clk);
    check("stall_b0", sout_l, 0);
    check("stall_b0_start", fs_l, 1);
    @(posedge clk); #1;
    shift_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("stall_hold_sout", sout_l, 0);
      check("stall_hold_ready", lr_l, 0);
      check("stall_hold_valid", sv_l, 1);
      check("stall_hold_start", fs_l, 0);
    end
    @(posedge clk); #1;
    shift_en = 1'b1;
    @(negedge clk);
    check("stall_b1", sout_l, 0);
    check("stall_b1_ready", lr_l, 0);
    @(negedge clk);
    check("stall_b2", sout_l, 1);
    @(negedge clk);
    check("stall_b3", sout_l, 1);
    check("stall_b3_last", fl_l, 1);
    check("stall_b3_ready", lr_l, 1);
    @(negedge clk);
    check("stall_end_valid", sv_l, 0);

    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data = 4'hF;
    @(negedge clk);
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", lr_l, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_sout", sout_l, 0);
    check("mid_rst_valid", sv_l, 0);
    check("mid_rst_busy", busy_l, 0);
    check("mid_rst_ready_up", lr_l, 1);
    load_word("after_rst", 4'h3, 4'b0011, 4'b1100);

    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_data = 4'($urandom);
      shift_en = ($urandom_range(0, 3) != 0);
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 50) begin
        @(negedge clk);
        acc = lr_l;
        cyc++;
        if (!acc) begin
          @(posedge clk); #1;
          shift_en = ($urandom_range(0, 3) != 0);
        end
      end
      if (!acc) check("rand_accept_timeout", 0, 1);
      @(posedge clk); #1;
      load_valid = 1'b0;
      shift_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          shift_en = ($urandom_range(0, 3) != 0);
        end
      end
    end
    @(posedge clk); #1;
    shift_en = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("drain_valid", sv_l, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
